// File: rtl/fwd_sched_if.sv
// ID-stage <-> forwarding scheduler interface.
// The ID stage (master) presents the instruction it holds and the pipeline
// control events. The scheduler (slave) returns operand-mux selects, the
// load-use stall and the stall performance counter.
interface fwd_sched_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    // Instruction currently held in ID
    logic             id_valid;
    logic [REG_W-1:0] id_rj;
    logic             id_rj_used;
    logic [REG_W-1:0] id_rk;
    logic             id_rk_used;
    logic [REG_W-1:0] id_rd;
    logic             id_we;
    logic             id_is_load;

    // Pipeline control events
    logic             freeze;
    logic             flush_id;
    logic             flush_all;

    // Scheduler results
    logic [2:0]       fwd_rj;
    logic [2:0]       fwd_rk;
    logic             id_stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rj, id_rj_used, id_rk, id_rk_used,
               id_rd, id_we, id_is_load, freeze, flush_id, flush_all,
        input  fwd_rj, fwd_rk, id_stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rj, id_rj_used, id_rk, id_rk_used,
               id_rd, id_we, id_is_load, freeze, flush_id, flush_all,
        output fwd_rj, fwd_rk, id_stall, stall_cnt
    );
endinterface

// File: rtl/fwd_sched.sv
// Forwarding / load-use hazard scheduler for the ID stage.
// A shadow scoreboard mirrors the destination of the instructions in EX,
// MM1, MM2 and WB. Each cycle the ID source operands are matched against it,
// youngest stage first, to choose the operand-mux source. A load still in
// EX or MM1 cannot supply data yet, so its consumer is held in ID.
//
// Select encodings (shared with the ID operand muxes):
//   0 GR       register file
//   1 EX       EX result
//   2 MM1      MM1 result
//   3 MM2_REG  MM2 ALU result
//   4 MM2_MEM  MM2 load data
//   5 WB       WB result
module fwd_sched #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input logic        clk,
    input logic        reset,
    fwd_sched_if.slave bus
);

    localparam logic [2:0] FWD_SRC_GR      = 3'd0;
    localparam logic [2:0] FWD_SRC_EX      = 3'd1;
    localparam logic [2:0] FWD_SRC_MM1     = 3'd2;
    localparam logic [2:0] FWD_SRC_MM2_REG = 3'd3;
    localparam logic [2:0] FWD_SRC_MM2_MEM = 3'd4;
    localparam logic [2:0] FWD_SRC_WB      = 3'd5;

    // One in-flight destination as seen from ID
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } entry_t;

    // Outcome of resolving one source operand
    typedef struct packed {
        logic       hazard;
        logic [2:0] sel;
    } resolve_t;

    entry_t   ex_q, mm1_q, mm2_q, wb_q;
    entry_t   ex_d;
    resolve_t rj_res, rk_res;
    logic     stall;
    logic     count_en;

    // True when stage entry e will write source register s of a live read.
    // r0 is hard-wired to zero, so it never forwards.
    function automatic logic hit(
        input entry_t           e,
        input logic [REG_W-1:0] s,
        input logic             used,
        input logic             valid
    );
        return e.valid & e.we & (e.rd == s) & (s != '0) & used & valid;
    endfunction

    // Youngest matching writer decides; an older match is shadowed by it.
    function automatic resolve_t resolve(
        input logic [REG_W-1:0] s,
        input logic             used,
        input logic             valid,
        input entry_t           ex,
        input entry_t           mm1,
        input entry_t           mm2,
        input entry_t           wb
    );
        resolve_t r;
        r.hazard = 1'b0;
        r.sel    = FWD_SRC_GR;
        if (hit(ex, s, used, valid)) begin
            // Load data is not available until MM2
            if (ex.is_load) r.hazard = 1'b1;
            else            r.sel    = FWD_SRC_EX;
        end else if (hit(mm1, s, used, valid)) begin
            if (mm1.is_load) r.hazard = 1'b1;
            else             r.sel    = FWD_SRC_MM1;
        end else if (hit(mm2, s, used, valid)) begin
            r.sel = mm2.is_load ? FWD_SRC_MM2_MEM : FWD_SRC_MM2_REG;
        end else if (hit(wb, s, used, valid)) begin
            r.sel = FWD_SRC_WB;
        end
        return r;
    endfunction

    // Resolve both operands and derive the stall from the current shadow state
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        rj_res = '0;
        rk_res = '0;
        ex_d   = '0;

        rj_res = resolve(bus.id_rj, bus.id_rj_used, bus.id_valid,
                         ex_q, mm1_q, mm2_q, wb_q);
        rk_res = resolve(bus.id_rk, bus.id_rk_used, bus.id_valid,
                         ex_q, mm1_q, mm2_q, wb_q);

        stall = rj_res.hazard | rk_res.hazard;

        // A stalled or killed ID instruction becomes a bubble in EX
        ex_d.valid   = bus.id_valid & ~stall & ~bus.flush_id;
        ex_d.rd      = bus.id_rd;
        ex_d.we      = bus.id_we;
        ex_d.is_load = bus.id_is_load;
    end

    // The held instruction re-reads the register file once it is released,
    // so the selects are parked on GR while stalled.
    assign bus.fwd_rj   = stall ? FWD_SRC_GR : rj_res.sel;
    assign bus.fwd_rk   = stall ? FWD_SRC_GR : rk_res.sel;
    assign bus.id_stall = stall;

    // A stall cycle is only counted when the pipeline actually advances
    assign count_en = stall & ~bus.freeze & ~bus.flush_all;

    // Shadow scoreboard: shift one stage per cycle, flush beats freeze
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the four entries are ordinary flops, not a RAM, so they
            // are cleared by reset like any other control state.
            ex_q  <= '0;
            mm1_q <= '0;
            mm2_q <= '0;
            wb_q  <= '0;
        end else if (bus.flush_all) begin
            ex_q  <= '0;
            mm1_q <= '0;
            mm2_q <= '0;
            wb_q  <= '0;
        end else if (!bus.freeze) begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of its predecessor, giving a true shift rather than a
            // fall-through.
            wb_q  <= mm2_q;
            mm2_q <= mm1_q;
            mm1_q <= ex_q;
            ex_q  <= ex_d;
        end
    end

    // Stall performance counter, free-running and wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.stall_cnt <= '0;
        end else if (count_en) begin
            bus.stall_cnt <= bus.stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_sched.sv
// Directed bench for fwd_sched: forwarding priority, load-use stalls,
// freeze/flush interaction and the stall counter.
module tb_fwd_sched;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    localparam logic [2:0] GR   = 3'd0;
    localparam logic [2:0] EX   = 3'd1;
    localparam logic [2:0] MM1  = 3'd2;
    localparam logic [2:0] MM2R = 3'd3;
    localparam logic [2:0] MM2M = 3'd4;
    localparam logic [2:0] WB   = 3'd5;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fwd_sched_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_sched #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {id_stall, fwd_rj, fwd_rk}
    function automatic logic [6:0] outs();
        return {bus.id_stall, bus.fwd_rj, bus.fwd_rk};
    endfunction

    task automatic instr(input int v, input int rj, input int rju,
                         input int rk, input int rku,
                         input int rd, input int we, input int ld);
        bus.id_valid   = (v != 0);
        bus.id_rj      = REG_W'(rj);
        bus.id_rj_used = (rju != 0);
        bus.id_rk      = REG_W'(rk);
        bus.id_rk_used = (rku != 0);
        bus.id_rd      = REG_W'(rd);
        bus.id_we      = (we != 0);
        bus.id_is_load = (ld != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.freeze    = 1'b0;
        bus.flush_id  = 1'b0;
        bus.flush_all = 1'b0;
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.freeze    = 1'b0;
        bus.flush_id  = 1'b0;
        bus.flush_all = 1'b0;
        instr(1, 5, 1, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if (outs() !== {1'b0, GR, GR}) begin
            miscompares++;
            $display("FAIL reset_outs: got %b want %b", outs(), {1'b0, GR, GR});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (outs() !== {1'b0, GR, GR}) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", outs(), {1'b0, GR, GR});
        end
        vectors++;
        if (bus.stall_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt);
        end
        tick();
    endtask

    task automatic test_alu_forward();
        logic [2:0] exp_seq [5];
        exp_seq = '{EX, MM1, MM2R, WB, GR};
        do_reset();
        instr(1, 0, 0, 0, 0, 3, 1, 0);       // ALU writes r3
        tick();
        for (int i = 0; i < 5; i++) begin
            instr(1, 3, 1, 3, 1, 0, 0, 0);   // independent reader of r3
            #1;
            vectors++;
            if (outs() !== {1'b0, exp_seq[i], exp_seq[i]}) begin
                miscompares++;
                $display("FAIL alu_fwd_step%0d: got %b want %b", i, outs(),
                         {1'b0, exp_seq[i], exp_seq[i]});
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        instr(1, 0, 0, 0, 0, 2, 1, 0);       // ALU writes r2
        tick();
        instr(1, 0, 0, 0, 0, 7, 1, 1);       // load r7
        tick();
        instr(1, 2, 1, 7, 1, 0, 0, 0);       // reads r2 and r7
        #1;
        vectors++;
        if (outs() !== {1'b1, GR, GR}) begin
            miscompares++;
            $display("FAIL load_use_c1: got %b want %b", outs(), {1'b1, GR, GR});
        end
        tick();
        vectors++;
        if (outs() !== {1'b1, GR, GR}) begin
            miscompares++;
            $display("FAIL load_use_c2: got %b want %b", outs(), {1'b1, GR, GR});
        end
        tick();
        vectors++;
        if (outs() !== {1'b0, WB, MM2M}) begin
            miscompares++;
            $display("FAIL load_use_c3: got %b want %b", outs(), {1'b0, WB, MM2M});
        end
        vectors++;
        if (bus.stall_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL load_use_cnt: got %0d want 2", bus.stall_cnt);
        end

        // One independent instruction between load and use: single stall
        do_reset();
        instr(1, 0, 0, 0, 0, 8, 1, 1);       // load r8
        tick();
        instr(1, 0, 0, 0, 0, 0, 0, 0);       // independent
        tick();
        instr(1, 8, 1, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if (outs() !== {1'b1, GR, GR}) begin
            miscompares++;
            $display("FAIL load_gap_c1: got %b want %b", outs(), {1'b1, GR, GR});
        end
        tick();
        vectors++;
        if (outs() !== {1'b0, MM2M, GR}) begin
            miscompares++;
            $display("FAIL load_gap_c2: got %b want %b", outs(), {1'b0, MM2M, GR});
        end
        vectors++;
        if (bus.stall_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL load_gap_cnt: got %0d want 1", bus.stall_cnt);
        end
    endtask

    task automatic test_youngest();
        do_reset();
        instr(1, 0, 0, 0, 0, 4, 1, 0);       // older ALU r4
        tick();
        instr(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        instr(1, 0, 0, 0, 0, 4, 1, 0);       // younger ALU r4
        tick();
        instr(1, 4, 1, 4, 1, 0, 0, 0);       // MM2=r4 old, EX=r4 young
        #1;
        vectors++;
        if (outs() !== {1'b0, EX, EX}) begin
            miscompares++;
            $display("FAIL youngest_ex: got %b want %b", outs(), {1'b0, EX, EX});
        end
        tick();
        #1;                                  // MM1=r4 young, WB=r4 old
        vectors++;
        if (outs() !== {1'b0, MM1, MM1}) begin
            miscompares++;
            $display("FAIL youngest_mm1: got %b want %b", outs(), {1'b0, MM1, MM1});
        end
        instr(1, 4, 0, 4, 1, 0, 0, 0);       // rj not read
        #1;
        vectors++;
        if (outs() !== {1'b0, GR, MM1}) begin
            miscompares++;
            $display("FAIL unused_rj: got %b want %b", outs(), {1'b0, GR, MM1});
        end
        instr(0, 4, 1, 4, 1, 0, 0, 0);       // ID empty
        #1;
        vectors++;
        if (outs() !== {1'b0, GR, GR}) begin
            miscompares++;
            $display("FAIL id_invalid: got %b want %b", outs(), {1'b0, GR, GR});
        end
        tick();
        instr(1, 0, 0, 0, 0, 0, 1, 0);       // writes r0
        tick();
        instr(1, 0, 1, 0, 1, 0, 0, 0);       // reads r0
        #1;
        vectors++;
        if (outs() !== {1'b0, GR, GR}) begin
            miscompares++;
            $display("FAIL r0_never: got %b want %b", outs(), {1'b0, GR, GR});
        end
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        instr(1, 0, 0, 0, 0, 9, 1, 1);       // load r9
        tick();
        instr(1, 9, 1, 0, 0, 0, 0, 0);
        bus.freeze = 1'b1;
        #1;
        vectors++;
        if (outs() !== {1'b1, GR, GR}) begin
            miscompares++;
            $display("FAIL freeze_enter: got %b want %b", outs(), {1'b1, GR, GR});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({outs(), bus.stall_cnt} !== {1'b1, GR, GR, 32'd0}) begin
                miscompares++;
                $display("FAIL freeze_hold%0d: got %b cnt %0d want %b cnt 0", i,
                         outs(), bus.stall_cnt, {1'b1, GR, GR});
            end
        end
        bus.freeze = 1'b0;
        tick();
        vectors++;
        if ({outs(), bus.stall_cnt} !== {1'b1, GR, GR, 32'd1}) begin
            miscompares++;
            $display("FAIL freeze_resume1: got %b cnt %0d want %b cnt 1",
                     outs(), bus.stall_cnt, {1'b1, GR, GR});
        end
        tick();
        vectors++;
        if ({outs(), bus.stall_cnt} !== {1'b0, MM2M, GR, 32'd2}) begin
            miscompares++;
            $display("FAIL freeze_resume2: got %b cnt %0d want %b cnt 2",
                     outs(), bus.stall_cnt, {1'b0, MM2M, GR});
        end
    endtask

    task automatic test_flush();
        // flush_all with a load in MM1 and its consumer waiting
        do_reset();
        instr(1, 0, 0, 0, 0, 6, 1, 1);       // load r6
        tick();
        instr(1, 6, 1, 0, 0, 0, 0, 0);
        tick();                              // counted stall, load now in MM1
        bus.flush_all = 1'b1;
        #1;
        vectors++;
        if (outs() !== {1'b1, GR, GR}) begin
            miscompares++;
            $display("FAIL flush_all_pre: got %b want %b", outs(), {1'b1, GR, GR});
        end
        tick();
        bus.flush_all = 1'b0;
        #1;
        vectors++;
        if ({outs(), bus.stall_cnt} !== {1'b0, GR, GR, 32'd1}) begin
            miscompares++;
            $display("FAIL flush_all_post: got %b cnt %0d want %b cnt 1",
                     outs(), bus.stall_cnt, {1'b0, GR, GR});
        end

        // flush_all wins over freeze
        do_reset();
        instr(1, 0, 0, 0, 0, 5, 1, 0);       // ALU r5
        tick();
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        bus.freeze    = 1'b1;
        bus.flush_all = 1'b1;
        tick();
        bus.freeze    = 1'b0;
        bus.flush_all = 1'b0;
        instr(1, 5, 1, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if (outs() !== {1'b0, GR, GR}) begin
            miscompares++;
            $display("FAIL flush_over_freeze: got %b want %b", outs(), {1'b0, GR, GR});
        end

        // flush_id during a stall still counts
        do_reset();
        instr(1, 0, 0, 0, 0, 10, 1, 1);      // load r10
        tick();
        instr(1, 0, 0, 10, 1, 0, 0, 0);
        bus.flush_id = 1'b1;
        #1;
        vectors++;
        if (outs() !== {1'b1, GR, GR}) begin
            miscompares++;
            $display("FAIL flush_id_stall: got %b want %b", outs(), {1'b1, GR, GR});
        end
        tick();
        bus.flush_id = 1'b0;
        vectors++;
        if (bus.stall_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL flush_id_cnt: got %0d want 1", bus.stall_cnt);
        end

        // flush_id kills the ID writer
        do_reset();
        instr(1, 0, 0, 0, 0, 11, 1, 0);      // ALU r11, killed
        bus.flush_id = 1'b1;
        tick();
        bus.flush_id = 1'b0;
        instr(1, 11, 1, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if (outs() !== {1'b0, GR, GR}) begin
            miscompares++;
            $display("FAIL flush_id_bubble: got %b want %b", outs(), {1'b0, GR, GR});
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        instr(1, 0, 0, 0, 0, 12, 1, 1);      // load r12
        tick();
        instr(1, 12, 1, 0, 0, 0, 0, 0);
        tick();                              // one stall counted
        vectors++;
        if ({bus.id_stall, bus.stall_cnt} !== {1'b1, 32'd1}) begin
            miscompares++;
            $display("FAIL mid_stall_pre: got stall %b cnt %0d want stall 1 cnt 1",
                     bus.id_stall, bus.stall_cnt);
        end
        reset = 1'b1;                        // asserted between edges
        #1;
        vectors++;
        if ({outs(), bus.stall_cnt} !== {1'b0, GR, GR, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_stall_reset: got %b cnt %0d want %b cnt 0",
                     outs(), bus.stall_cnt, {1'b0, GR, GR});
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest();
        test_freeze();
        test_flush();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
